dmem_port_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported 256x8 data memory. It shares the memory between the CPU load/store port (port 0) and the debug/loader port (port 1). Port 0 has fixed priority, port 1 has a starvation guarantee, and port 0 can lock the memory for read-modify-write sequences. It also tracks the memory's 1-cycle read latency and returns read data to the requester that issued the read.

---
 rtl/dmem_port_arbiter_if.sv | 46 ++++
 rtl/dmem_port_arbiter.sv | 80 ++++++++
 tb/tb_dmem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus for dmem_port_arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface dmem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_lock;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-ported data memory: port 0 priority with lock,
// port 1 starvation bound, and read-data steering for the 1-cycle memory latency.
module dmem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input logic                CLK,
  input logic                RST_N,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic {ARB, LOCK0} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [1:0]    rd_tag;
  logic          p0_gnt_c;
  logic          p1_gnt_c;
  logic          p1_forced;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

  assign p1_forced = (wait_cnt == 4'(MAX_WAIT));

  always_comb begin
    p1_gnt_c = 1'b0;
    p0_gnt_c = 1'b0;
    if (state == LOCK0) begin
      p0_gnt_c = bus.p0_req;
    end else begin
      p1_gnt_c = bus.p1_req && (p1_forced || !bus.p0_req);
      p0_gnt_c = bus.p0_req && !p1_gnt_c;
    end
  end

  always_comb begin
    addr_sel  = bus.p0_addr;
    wdata_sel = bus.p0_wdata;
    if (p1_gnt_c) begin
      addr_sel  = bus.p1_addr;
      wdata_sel = bus.p1_wdata;
    end
  end

  assign bus.p0_gnt    = p0_gnt_c;
  assign bus.p1_gnt    = p1_gnt_c;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.mem_we    = (p0_gnt_c & bus.p0_we) | (p1_gnt_c & bus.p1_we);

  assign bus.p0_rvalid = rd_tag[0];
  assign bus.p1_rvalid = rd_tag[1];
  assign bus.p0_rdata  = bus.mem_rdata;
  assign bus.p1_rdata  = bus.mem_rdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ARB;
      wait_cnt <= '0;
      rd_tag   <= '0;
    end else begin
      rd_tag <= {p1_gnt_c & !bus.p1_we, p0_gnt_c & !bus.p0_we};

      case (state)
        ARB:     if (p0_gnt_c && bus.p0_lock) state <= LOCK0;
        LOCK0:   if (!bus.p0_lock) state <= ARB;
        default: state <= ARB;
      endcase

      // Keeps counting (saturated) through LOCK0 so port 1 wins the first ARB cycle.
      if (p1_gnt_c || !bus.p1_req) begin
        wait_cnt <= '0;
      end else if (!p1_forced) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a registered-read 256x8 memory model.
module tb_dmem_port_arbiter;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  logic [7:0] mem [256];

  dmem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

  dmem_port_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory preloads Memory[i]=i while reset is held; registered read port.
  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_lock = 0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
  endtask

  task automatic test_reset();
    idle();
    RST_N = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_rvalid: got %b%b want 00", bus.p1_rvalid, bus.p0_rvalid);
    end
    checks++;
    if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: got p0=%b p1=%b we=%b want 0 0 0", bus.p0_gnt, bus.p1_gnt, bus.mem_we);
    end
    @(posedge CLK); #1;
    RST_N = 1;
  endtask

  task automatic test_uncontended_read();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 8'd10;
    @(negedge CLK);
    checks++;
    if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0 || bus.mem_addr !== 8'd10 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL uncont_gnt: got gnt=%b%b addr=%h we=%b want 01 0a 0", bus.p1_gnt, bus.p0_gnt, bus.mem_addr, bus.mem_we);
    end
    step();
    idle();
    @(negedge CLK);
    checks++;
    if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 8'h0A || bus.p1_rvalid !== 1'b0) begin
      errors++; $display("FAIL uncont_ret: got v0=%b d=%h v1=%b want 1 0a 0", bus.p0_rvalid, bus.p0_rdata, bus.p1_rvalid);
    end
    step();
    @(negedge CLK);
    checks++;
    if (bus.p0_rvalid !== 1'b0) begin
      errors++; $display("FAIL uncont_once: got v0=%b want 0", bus.p0_rvalid);
    end
    step();
  endtask

  task automatic test_write_read();
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 8'h33; bus.p1_wdata = 8'h5A;
    @(negedge CLK);
    checks++;
    if (bus.p1_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h33 || bus.mem_wdata !== 8'h5A) begin
      errors++; $display("FAIL wr_issue: got gnt=%b we=%b addr=%h wd=%h want 1 1 33 5a", bus.p1_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    step();
    idle();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 8'h33;
    @(negedge CLK);
    checks++;
    if (bus.p1_rvalid !== 1'b0 || bus.p0_rvalid !== 1'b0 || bus.p0_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL wr_norv: got v1=%b v0=%b g0=%b we=%b want 0 0 1 0", bus.p1_rvalid, bus.p0_rvalid, bus.p0_gnt, bus.mem_we);
    end
    step();
    idle();
    @(negedge CLK);
    checks++;
    if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 8'h5A || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL wr_readback: got v0=%b d=%h we=%b want 1 5a 0", bus.p0_rvalid, bus.p0_rdata, bus.mem_we);
    end
    step();
  endtask

  task automatic test_starvation();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 8'd1;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 8'd7;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checks++;
      if (bus.p1_gnt !== 1'b0 || bus.p0_gnt !== 1'b1) begin
        errors++; $display("FAIL starve_deny c%0d: got g1=%b g0=%b want 0 1", c, bus.p1_gnt, bus.p0_gnt);
      end
      step();
    end
    @(negedge CLK);
    checks++;
    if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0 || bus.mem_addr !== 8'd7) begin
      errors++; $display("FAIL starve_force: got g1=%b g0=%b addr=%h want 1 0 07", bus.p1_gnt, bus.p0_gnt, bus.mem_addr);
    end
    step();
    bus.p1_req = 0;
    @(negedge CLK);
    checks++;
    if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 8'h07 || bus.p0_rvalid !== 1'b0 || bus.p0_gnt !== 1'b1) begin
      errors++; $display("FAIL starve_ret: got v1=%b d=%h v0=%b g0=%b want 1 07 0 1", bus.p1_rvalid, bus.p1_rdata, bus.p0_rvalid, bus.p0_gnt);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_lock();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 8'd2; bus.p0_lock = 1;
    @(negedge CLK);
    checks++;
    if (bus.p0_gnt !== 1'b1) begin
      errors++; $display("FAIL lock_enter: got g0=%b want 1", bus.p0_gnt);
    end
    step();
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 8'd9;
    for (int i = 0; i < 10; i++) begin
      logic exp_g0;
      exp_g0 = (i % 2 == 0);
      bus.p0_req = exp_g0;
      @(negedge CLK);
      checks++;
      if (bus.p1_gnt !== 1'b0 || bus.p0_gnt !== exp_g0) begin
        errors++; $display("FAIL lock_hold i%0d: got g1=%b g0=%b want 0 %b", i, bus.p1_gnt, bus.p0_gnt, exp_g0);
      end
      step();
    end
    checks++;
    if (dut.wait_cnt !== 4'd4) begin
      errors++; $display("FAIL lock_waitsat: got %0d want 4", dut.wait_cnt);
    end
    bus.p0_lock = 0; bus.p0_req = 0;
    @(negedge CLK);
    checks++;
    if (bus.p1_gnt !== 1'b0) begin
      errors++; $display("FAIL lock_release_cycle: got g1=%b want 0", bus.p1_gnt);
    end
    step();
    bus.p0_req = 1;
    @(negedge CLK);
    checks++;
    if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0 || bus.mem_addr !== 8'd9) begin
      errors++; $display("FAIL lock_first_arb: got g1=%b g0=%b addr=%h want 1 0 09", bus.p1_gnt, bus.p0_gnt, bus.mem_addr);
    end
    step();
    idle();
    @(negedge CLK);
    checks++;
    if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 8'h09) begin
      errors++; $display("FAIL lock_ret: got v1=%b d=%h want 1 09", bus.p1_rvalid, bus.p1_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 8'd3;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 8'd4;
    @(negedge CLK);
    checks++;
    if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
      errors++; $display("FAIL b2b_prio: got g0=%b g1=%b want 1 0", bus.p0_gnt, bus.p1_gnt);
    end
    step();
    bus.p0_req = 0;
    @(negedge CLK);
    checks++;
    if (bus.p1_gnt !== 1'b1 || bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 8'h03 || bus.p1_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got g1=%b v0=%b d=%h v1=%b want 1 1 03 0", bus.p1_gnt, bus.p0_rvalid, bus.p0_rdata, bus.p1_rvalid);
    end
    step();
    idle();
    @(negedge CLK);
    checks++;
    if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 8'h04 || bus.p0_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got v1=%b d=%h v0=%b want 1 04 0", bus.p1_rvalid, bus.p1_rdata, bus.p0_rvalid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 8'd5; bus.p0_lock = 1;
    @(negedge CLK);
    checks++;
    if (bus.p0_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_gnt: got g0=%b want 1", bus.p0_gnt);
    end
    step();
    RST_N = 0;
    bus.p0_req = 0;
    #1;
    checks++;
    if (bus.p0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got v0=%b want 0", bus.p0_rvalid);
    end
    @(negedge CLK);
    checks++;
    if (bus.p0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_hold: got v0=%b want 0", bus.p0_rvalid);
    end
    step();
    step();
    RST_N = 1;
    bus.p0_lock = 0;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 8'd6;
    @(negedge CLK);
    checks++;
    if (bus.p1_gnt !== 1'b1 || bus.p0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_arb: got g1=%b v0=%b want 1 0", bus.p1_gnt, bus.p0_rvalid);
    end
    step();
    idle();
    @(negedge CLK);
    checks++;
    if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 8'h06 || bus.p0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_ret: got v1=%b d=%h v0=%b want 1 06 0", bus.p1_rvalid, bus.p1_rdata, bus.p0_rvalid);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST_N  = 0;
    idle();
    test_reset();
    test_uncontended_read();
    test_write_read();
    test_starvation();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
